// File: rtl/lsu_mem_master_if.sv
// Request/response channel from the execute stage plus the word-wide data-memory port.
// The lsu_mem_master drives through the master modport; the environment uses slave.
interface lsu_mem_master_if;
  logic        Req_valid_i;
  logic        Req_ready_o;
  logic        Req_write_i;
  logic [2:0]  Req_funct3_i;
  logic [31:0] Req_addr_i;
  logic [31:0] Req_wdata_i;
  logic        Resp_valid_o;
  logic        Resp_ready_i;
  logic [31:0] Resp_data_o;
  logic        Resp_err_o;
  logic [31:0] Mem_addr_o;
  logic [31:0] Mem_wdata_o;
  logic        Mem_ren_o;
  logic        Mem_wen_o;
  logic [31:0] Mem_rdata_i;

  modport master (
    input  Req_valid_i, Req_write_i, Req_funct3_i, Req_addr_i, Req_wdata_i,
    input  Resp_ready_i, Mem_rdata_i,
    output Req_ready_o, Resp_valid_o, Resp_data_o, Resp_err_o,
    output Mem_addr_o, Mem_wdata_o, Mem_ren_o, Mem_wen_o
  );

  modport slave (
    output Req_valid_i, Req_write_i, Req_funct3_i, Req_addr_i, Req_wdata_i,
    output Resp_ready_i, Mem_rdata_i,
    input  Req_ready_o, Resp_valid_o, Resp_data_o, Resp_err_o,
    input  Mem_addr_o, Mem_wdata_o, Mem_ren_o, Mem_wen_o
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding RISC-V load/store initiator for a word-wide little-endian memory.
// Sub-word stores use read-modify-write; sub-word loads are sign/zero extended.
module lsu_mem_master #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_master_if.master  bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic [31:0] w_word_next;
  logic [31:0] r_resp_data;
  logic [31:0] w_resp_data_next;
  logic        r_resp_err;
  logic        w_resp_err_next;

  logic        w_accept;
  logic        w_fmt_err;
  logic        w_range_err;
  logic        w_req_err;
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_word;
  logic        w_mem_active;

  assign w_accept    = bus.Req_valid_i & bus.Req_ready_o;
  assign w_range_err = (bus.Req_addr_i >= 32'(ADDR_LIMIT));
  assign w_req_err   = w_fmt_err | w_range_err;

  // Encoding, store-legality and alignment checks on the incoming request
  always_comb begin
    w_fmt_err = 1'b1;
    case (bus.Req_funct3_i)
      F3_B:    w_fmt_err = 1'b0;
      F3_H:    w_fmt_err = bus.Req_addr_i[0];
      F3_W:    w_fmt_err = |bus.Req_addr_i[1:0];
      F3_BU:   w_fmt_err = bus.Req_write_i;
      F3_HU:   w_fmt_err = bus.Req_write_i | bus.Req_addr_i[0];
      default: w_fmt_err = 1'b1;
    endcase
  end

  assign w_lane = r_addr[1:0];
  assign w_byte = bus.Mem_rdata_i[{w_lane, 3'b000} +: 8];
  assign w_half = r_addr[1] ? bus.Mem_rdata_i[31:16] : bus.Mem_rdata_i[15:0];

  // Load result extraction and sub-word store merge from the word just read
  always_comb begin
    w_load_data  = 32'h0;
    w_merge_word = bus.Mem_rdata_i;
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    w_load_data = bus.Mem_rdata_i;
      F3_BU:   w_load_data = {24'h0, w_byte};
      F3_HU:   w_load_data = {16'h0, w_half};
      default: w_load_data = 32'h0;
    endcase
    if (r_funct3 == F3_B) begin
      w_merge_word[{w_lane, 3'b000} +: 8] = r_word[7:0];
    end else begin
      w_merge_word[{r_addr[1], 4'b0000} +: 16] = r_word[15:0];
    end
  end

  // Next-state and response/data-word updates
  always_comb begin
    w_state_next     = r_state;
    w_word_next      = r_word;
    w_resp_data_next = r_resp_data;
    w_resp_err_next  = r_resp_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_word_next = bus.Req_wdata_i;
          if (w_req_err) begin
            w_state_next     = S_RESP;
            w_resp_data_next = 32'h0;
            w_resp_err_next  = 1'b1;
          end else if (bus.Req_write_i && (bus.Req_funct3_i == F3_W)) begin
            w_state_next = S_WR;
          end else begin
            w_state_next = S_RD;
          end
        end
      end
      S_RD: begin
        if (r_write) begin
          w_word_next  = w_merge_word;
          w_state_next = S_WR;
        end else begin
          w_resp_data_next = w_load_data;
          w_resp_err_next  = 1'b0;
          w_state_next     = S_RESP;
        end
      end
      S_WR: begin
        w_resp_data_next = 32'h0;
        w_resp_err_next  = 1'b0;
        w_state_next     = S_RESP;
      end
      S_RESP: begin
        if (bus.Resp_ready_i) begin
          w_resp_data_next = 32'h0;
          w_resp_err_next  = 1'b0;
          w_state_next     = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_word      <= 32'h0;
      r_resp_data <= 32'h0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_word      <= w_word_next;
      r_resp_data <= w_resp_data_next;
      r_resp_err  <= w_resp_err_next;
      if (w_accept) begin
        r_write  <= bus.Req_write_i;
        r_funct3 <= bus.Req_funct3_i;
        r_addr   <= bus.Req_addr_i;
      end
    end
  end

  // Strobes and ready are state decodes, killed while reset is held
  assign bus.Req_ready_o  = (r_state == S_IDLE) & ~rst;
  assign bus.Mem_ren_o    = (r_state == S_RD) & ~rst;
  assign bus.Mem_wen_o    = (r_state == S_WR) & ~rst;
  assign w_mem_active     = bus.Mem_ren_o | bus.Mem_wen_o;
  assign bus.Mem_addr_o   = w_mem_active ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.Mem_wdata_o  = bus.Mem_wen_o ? r_word : 32'h0;
  assign bus.Resp_valid_o = (r_state == S_RESP);
  assign bus.Resp_data_o  = r_resp_data;
  assign bus.Resp_err_o   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: transaction-level timing/memory model checked every cycle,
// plus directed loads, stores, error cases, backpressure and reset-in-write.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  lsu_mem_master_if bus ();

  lsu_mem_master #(.ADDR_LIMIT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Environment memory driven only by the DUT strobes
  logic [31:0] env_mem [0:255];
  assign bus.Mem_rdata_i = env_mem[bus.Mem_addr_o[9:2]];
  always @(posedge clk) if (bus.Mem_wen_o === 1'b1) env_mem[bus.Mem_addr_o[9:2]] <= bus.Mem_wdata_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: no event within bound at %0t", nm, $time);
  endtask

  // Transaction model: one outstanding request; m_cnt = cycles since acceptance
  logic [31:0] ref_mem [0:255];
  bit          m_busy = 1'b0;
  bit          m_seen_rst = 1'b0;
  int          m_cnt, m_lat, m_rd, m_wr;
  logic [31:0] m_data, m_waddr, m_wdata;
  logic        m_err;

  task automatic model_accept();
    logic [31:0] a, wd, word, val, mask;
    logic [2:0]  f3;
    logic        w, legal;
    int          sz, sh;
    a  = bus.Req_addr_i;
    wd = bus.Req_wdata_i;
    f3 = bus.Req_funct3_i;
    w  = bus.Req_write_i;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(w && f3[2]) &&
            ((a % sz) == 0) && (a < 32'd1024);
    m_busy = 1'b1; m_cnt = 1; m_waddr = a & ~32'd3;
    m_data = 32'h0; m_err = 1'b0; m_rd = 0; m_wr = 0; m_wdata = 32'h0;
    if (!legal) begin
      m_err = 1'b1; m_lat = 1;
    end else begin
      word = ref_mem[a[9:2]];
      sh   = 8 * int'(a % 4);
      if (!w) begin
        m_rd = 1; m_lat = 2;
        val  = word >> sh;
        if (sz < 4) begin
          mask = (32'd1 << (8 * sz)) - 32'd1;
          val  = val & mask;
          if (!f3[2] && val[8*sz-1]) val = val | ~mask;
        end
        m_data = val;
      end else if (sz == 4) begin
        m_wr = 1; m_lat = 2; m_wdata = wd;
      end else begin
        m_rd = 1; m_wr = 2; m_lat = 3;
        mask    = ((32'd1 << (8 * sz)) - 32'd1) << sh;
        m_wdata = (word & ~mask) | ((wd << sh) & mask);
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_seen_rst = 1'b1;
    end else if (!m_busy) begin
      if (bus.Req_valid_i) model_accept();
    end else begin
      if (m_wr != 0 && m_cnt == m_wr) ref_mem[m_waddr[9:2]] = m_wdata;
      if (m_cnt >= m_lat && bus.Resp_ready_i) m_busy = 1'b0;
      else if (m_cnt < m_lat) m_cnt++;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    logic e_ren, e_wen, e_val;
    if (m_seen_rst) begin
      e_ren = m_busy && (m_cnt == m_rd) && !rst;
      e_wen = m_busy && (m_cnt == m_wr) && !rst;
      e_val = m_busy && (m_cnt >= m_lat);
      chk("req_ready", 32'(bus.Req_ready_o), 32'(!m_busy && !rst));
      chk("mem_ren", 32'(bus.Mem_ren_o), 32'(e_ren));
      chk("mem_wen", 32'(bus.Mem_wen_o), 32'(e_wen));
      chk("mem_addr", bus.Mem_addr_o, (e_ren || e_wen) ? m_waddr : 32'h0);
      chk("mem_wdata", bus.Mem_wdata_o, e_wen ? m_wdata : 32'h0);
      chk("resp_valid", 32'(bus.Resp_valid_o), 32'(e_val));
      if (e_val) begin
        chk("resp_data", bus.Resp_data_o, m_data);
        chk("resp_err", 32'(bus.Resp_err_o), 32'(m_err));
      end
    end
  end

  task automatic drive_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.Req_valid_i  = 1'b1;
    bus.Req_write_i  = w;
    bus.Req_funct3_i = f3;
    bus.Req_addr_i   = a;
    bus.Req_wdata_i  = wd;
  endtask

  task automatic wait_accept(output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Req_ready_o === 1'b1) begin acc = 1'b1; break; end
      waited++;
    end
    if (!acc) timeout_fail("accept");
    @(posedge clk); #2;
    bus.Req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int bp, output logic [31:0] d, output logic e, output int lat);
    bit got;
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Resp_valid_o === 1'b1) begin got = 1'b1; break; end
      lat++;
    end
    if (!got) timeout_fail("resp");
    d = bus.Resp_data_o;
    e = bus.Resp_err_o;
    if (bp == 0) bus.Resp_ready_i = 1'b1;
    else begin
      repeat (bp) @(posedge clk);
      #2 bus.Resp_ready_i = 1'b1;
    end
    @(posedge clk); #2;
    bus.Resp_ready_i = 1'b0;
  endtask

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] d, output logic e,
                     output int lat);
    int waited;
    @(posedge clk); #2;
    drive_req(w, f3, a, wd);
    wait_accept(waited);
    wait_resp(0, d, e, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, waited;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    env_mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    bus.Req_valid_i = 1'b0; bus.Req_write_i = 1'b0; bus.Req_funct3_i = 3'b0;
    bus.Req_addr_i = 32'h0; bus.Req_wdata_i = 32'h0; bus.Resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", 32'(bus.Req_ready_o), 32'd1);
    chk("rst_valid", 32'(bus.Resp_valid_o), 32'd0);
    chk("rst_data", bus.Resp_data_o, 32'h0);
    chk("rst_err", 32'(bus.Resp_err_o), 32'd0);
    chk("rst_strobes", {30'h0, bus.Mem_ren_o, bus.Mem_wen_o}, 32'd0);

    txn(1'b0, 3'b000, 32'h11, 32'h0, d, e, lat);
    chk("lb_data", d, 32'hFFFFFFAA);
    chk("lb_lat", 32'(lat), 32'd2);
    txn(1'b0, 3'b100, 32'h11, 32'h0, d, e, lat);
    chk("lbu_data", d, 32'h000000AA);
    txn(1'b0, 3'b001, 32'h12, 32'h0, d, e, lat);
    chk("lh_data", d, 32'hFFFF8899);
    txn(1'b0, 3'b101, 32'h12, 32'h0, d, e, lat);
    chk("lhu_data", d, 32'h00008899);

    txn(1'b1, 3'b000, 32'h12, 32'h123456CC, d, e, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_err", 32'(e), 32'd0);
    chk("sb_mem", env_mem[4], 32'h88CCAABB);

    txn(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, d, e, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_mem", env_mem[5], 32'hDEADBEEF);
    txn(1'b0, 3'b010, 32'h14, 32'h0, d, e, lat);
    chk("lw_data", d, 32'hDEADBEEF);

    txn(1'b0, 3'b001, 32'h13, 32'h0, d, e, lat);
    chk("err_lh_mis", {30'h0, e, lat == 1}, 32'd3);
    txn(1'b1, 3'b010, 32'h16, 32'h0, d, e, lat);
    chk("err_sw_mis", {30'h0, e, lat == 1}, 32'd3);
    txn(1'b0, 3'b011, 32'h10, 32'h0, d, e, lat);
    chk("err_f3_011", {30'h0, e, lat == 1}, 32'd3);
    txn(1'b1, 3'b100, 32'h10, 32'h55, d, e, lat);
    chk("err_st_f3_100", {30'h0, e, lat == 1}, 32'd3);
    txn(1'b0, 3'b010, 32'h400, 32'h0, d, e, lat);
    chk("err_range", {30'h0, e, lat == 1}, 32'd3);
    chk("err_no_write", env_mem[4], 32'h88CCAABB);

    // Backpressure with the next request already waiting
    @(posedge clk); #2;
    drive_req(1'b0, 3'b010, 32'h10, 32'h0);
    wait_accept(waited);
    drive_req(1'b0, 3'b100, 32'h11, 32'h0);
    wait_resp(3, d, e, lat);
    chk("bp_data", d, 32'h88CCAABB);
    wait_accept(waited);
    chk("bp_accept_wait", 32'(waited), 32'd0);
    wait_resp(0, d, e, lat);
    chk("bp_next_data", d, 32'h000000AA);

    // Reset during the WR cycle of an SB
    @(posedge clk); #2;
    drive_req(1'b1, 3'b000, 32'h10, 32'h00000077);
    wait_accept(waited);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rstwr_wen", 32'(bus.Mem_wen_o), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwr_ready", 32'(bus.Req_ready_o), 32'd1);
    chk("rstwr_valid", 32'(bus.Resp_valid_o), 32'd0);
    chk("rstwr_data", bus.Resp_data_o, 32'h0);
    chk("rstwr_mem", env_mem[4], 32'h88CCAABB);
    txn(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
    chk("rstwr_lw", d, 32'h88CCAABB);
    chk("rstwr_lw_err", 32'(e), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
